// File: rtl/clock_request_join.sv
// Joins N child clock requests onto one upstream clock gate and fans its status back out.
// Optional CLOCK_JOIN_PROTOCOL_CHECK_EN adds a sticky protocol_error output for parent handshake violations.
module clock_request_join #(
   parameter int N_CHILD     = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int HOLD_W      = 8
) (
   input  logic               clock,
   input  logic               reset,
   output logic               parent_request,
   input  logic               parent_ready,
   input  logic               parent_silent,
   input  logic               parent_starting,
   input  logic               parent_stopping,
   input  logic [N_CHILD-1:0] child_request,
   output logic [N_CHILD-1:0] child_ready,
   output logic               child_silent,
   output logic               child_starting,
   output logic               child_stopping
`ifdef CLOCK_JOIN_PROTOCOL_CHECK_EN
   ,
   output logic               protocol_error
`endif
);

   typedef enum logic [2:0] {SILENT, STARTING, RUN, LINGER, STOPPING} state_t;

   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              any_req;
   logic              unused_status;

   assign any_req       = |child_request;
   assign unused_status = parent_starting ^ parent_stopping;

   // Outputs are registered alongside the state, so each transition sets them explicitly.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= SILENT;
         hold_cnt       <= '0;
         parent_request <= 1'b0;
         child_ready    <= '0;
         child_silent   <= 1'b1;
         child_starting <= 1'b0;
         child_stopping <= 1'b0;
      end else begin
         child_ready <= '0;
         case (state)
            SILENT: if (any_req && parent_silent) begin
               state          <= STARTING;
               parent_request <= 1'b1;
               child_silent   <= 1'b0;
               child_starting <= 1'b1;
            end
            STARTING: if (parent_ready) begin
               state          <= RUN;
               child_starting <= 1'b0;
               child_ready    <= child_request;
            end
            RUN: begin
               if (!parent_ready) begin
                  state          <= STARTING;
                  child_starting <= 1'b1;
               end else if (!any_req) begin
                  if (HOLD_CYCLES == 0) begin
                     state          <= STOPPING;
                     parent_request <= 1'b0;
                     child_stopping <= 1'b1;
                  end else begin
                     state    <= LINGER;
                     hold_cnt <= HOLD_INIT;
                  end
               end else begin
                  child_ready <= child_request;
               end
            end
            LINGER: begin
               if (!parent_ready) begin
                  state          <= STARTING;
                  hold_cnt       <= '0;
                  child_starting <= 1'b1;
               end else if (any_req) begin
                  state       <= RUN;
                  hold_cnt    <= '0;
                  child_ready <= child_request;
               end else if (hold_cnt <= HOLD_W'(1)) begin
                  state          <= STOPPING;
                  hold_cnt       <= '0;
                  parent_request <= 1'b0;
                  child_stopping <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            STOPPING: if (parent_silent) begin
               state          <= SILENT;
               child_stopping <= 1'b0;
               child_silent   <= 1'b1;
            end
            default: begin
               state          <= SILENT;
               hold_cnt       <= '0;
               parent_request <= 1'b0;
               child_silent   <= 1'b1;
               child_starting <= 1'b0;
               child_stopping <= 1'b0;
            end
         endcase
      end
   end

`ifdef CLOCK_JOIN_PROTOCOL_CHECK_EN
   logic       req_seen;
   logic       silent_low;
   logic [7:0] stop_cnt;
   logic       violation;

   // stop_cnt saturates; reaching 255 means this is at least the 256th such cycle.
   assign violation = (parent_ready && parent_silent)
                    || ((state == RUN || state == LINGER) && !parent_ready)
                    || (state == SILENT && !parent_silent && silent_low && !req_seen)
                    || (state == STOPPING && parent_ready && stop_cnt == 8'hff);

   always_ff @(posedge clock) begin
      if (reset) begin
         protocol_error <= 1'b0;
         req_seen       <= 1'b0;
         silent_low     <= 1'b0;
         stop_cnt       <= '0;
      end else begin
         if (parent_request) req_seen <= 1'b1;
         silent_low <= (state == SILENT) && !parent_silent;
         if (state == STOPPING && parent_ready)
            stop_cnt <= (stop_cnt == 8'hff) ? stop_cnt : stop_cnt + 8'd1;
         else
            stop_cnt <= '0;
         if (violation) protocol_error <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_clock_request_join.sv
// Scoreboard bench for clock_request_join: per-step expectations queued at drive time, popped after the edge.
module tb_clock_request_join;

   typedef struct packed {
      logic       rst;
      logic [3:0] creq;
      logic       pr;
      logic       ps;
      logic [7:0] exp;   // {parent_request, child_ready[3:0], silent, starting, stopping}
      logic       err;
   } stim_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       parent_ready = 1'b0, parent_silent = 1'b1;
   logic       parent_starting = 1'b0, parent_stopping = 1'b0;
   logic [3:0] child_request = '0;
   logic       parent_request, child_silent, child_starting, child_stopping;
   logic [3:0] child_ready;
   logic       parent_request0, child_silent0, child_starting0, child_stopping0;
   logic [3:0] child_ready0;
   logic       perr, perr0;
   logic [7:0] obs, obs0;
   logic [7:0] expq[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   assign obs  = {parent_request, child_ready, child_silent, child_starting, child_stopping};
   assign obs0 = {parent_request0, child_ready0, child_silent0, child_starting0, child_stopping0};

   clock_request_join #(.N_CHILD(4), .HOLD_CYCLES(8), .HOLD_W(8)) dut (
      .clock(clock), .reset(reset), .parent_request(parent_request),
      .parent_ready(parent_ready), .parent_silent(parent_silent),
      .parent_starting(parent_starting), .parent_stopping(parent_stopping),
      .child_request(child_request), .child_ready(child_ready),
      .child_silent(child_silent), .child_starting(child_starting),
      .child_stopping(child_stopping)
`ifdef CLOCK_JOIN_PROTOCOL_CHECK_EN
      , .protocol_error(perr)
`endif
   );

   clock_request_join #(.N_CHILD(4), .HOLD_CYCLES(0), .HOLD_W(8)) dut0 (
      .clock(clock), .reset(reset), .parent_request(parent_request0),
      .parent_ready(parent_ready), .parent_silent(parent_silent),
      .parent_starting(parent_starting), .parent_stopping(parent_stopping),
      .child_request(child_request), .child_ready(child_ready0),
      .child_silent(child_silent0), .child_starting(child_starting0),
      .child_stopping(child_stopping0)
`ifdef CLOCK_JOIN_PROTOCOL_CHECK_EN
      , .protocol_error(perr0)
`endif
   );

`ifndef CLOCK_JOIN_PROTOCOL_CHECK_EN
   assign perr  = 1'b0;
   assign perr0 = 1'b0;
`endif

   // Drive one cycle of stimulus, queue its expectation, and settle just past the edge.
   task automatic drive(input stim_t s);
      reset         = s.rst;
      child_request = s.creq;
      parent_ready  = s.pr;
      parent_silent = s.ps;
      expq.push_back(s.exp);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      stim_t t[2] = '{'{1'b1, 4'h0, 1'b0, 1'b1, 8'h04, 1'b0},
                      '{1'b0, 4'h0, 1'b0, 1'b1, 8'h04, 1'b0}};
      logic [7:0] e;
      for (int i = 0; i < 2; i++) begin
         drive(t[i]);
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL reset step %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_single_start();
      stim_t t[4] = '{'{1'b0, 4'h1, 1'b0, 1'b1, 8'h82, 1'b0},
                      '{1'b0, 4'h1, 1'b0, 1'b0, 8'h82, 1'b0},
                      '{1'b0, 4'h1, 1'b1, 1'b0, 8'h88, 1'b0},
                      '{1'b0, 4'h1, 1'b1, 1'b0, 8'h88, 1'b0}};
      logic [7:0] e;
      for (int i = 0; i < 4; i++) begin
         drive(t[i]);
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL single_start step %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_linger_hold();
      stim_t s;
      logic [7:0] e;
      for (int i = 0; i < 7; i++) begin
         s = '{1'b0, (i >= 5) ? 4'h4 : 4'h0, 1'b1, 1'b0, (i >= 5) ? 8'hA0 : 8'h80, 1'b0};
         drive(s);
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL linger_hold step %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_back_to_back();
      stim_t t[2] = '{'{1'b0, 4'h2, 1'b1, 1'b0, 8'h90, 1'b0},
                      '{1'b0, 4'h3, 1'b1, 1'b0, 8'h98, 1'b0}};
      logic [7:0] e;
      for (int i = 0; i < 2; i++) begin
         drive(t[i]);
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL back_to_back step %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_linger_expiry();
      stim_t s;
      logic [7:0] e;
      for (int i = 0; i < 9; i++) begin
         s = '{1'b0, 4'h0, 1'b1, 1'b0, (i == 8) ? 8'h01 : 8'h80, 1'b0};
         drive(s);
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL linger_expiry step %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_request_in_stopping();
      stim_t t[5] = '{'{1'b0, 4'h8, 1'b0, 1'b0, 8'h01, 1'b0},
                      '{1'b0, 4'h8, 1'b0, 1'b0, 8'h01, 1'b0},
                      '{1'b0, 4'h8, 1'b0, 1'b1, 8'h04, 1'b0},
                      '{1'b0, 4'h8, 1'b0, 1'b1, 8'h82, 1'b0},
                      '{1'b0, 4'h8, 1'b1, 1'b0, 8'hC0, 1'b0}};
      logic [7:0] e;
      for (int i = 0; i < 5; i++) begin
         drive(t[i]);
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL request_in_stopping step %0d: got %h want %h", i, obs, e); end
      end
   endtask

   task automatic test_reset_mid_run();
      stim_t t[6] = '{'{1'b0, 4'hF, 1'b1, 1'b0, 8'hF8, 1'b0},
                      '{1'b1, 4'hF, 1'b1, 1'b0, 8'h04, 1'b0},
                      '{1'b0, 4'hF, 1'b1, 1'b0, 8'h04, 1'b0},
                      '{1'b0, 4'hF, 1'b1, 1'b0, 8'h04, 1'b0},
                      '{1'b0, 4'hF, 1'b0, 1'b1, 8'h82, 1'b0},
                      '{1'b0, 4'hF, 1'b1, 1'b0, 8'hF8, 1'b0}};
      logic [7:0] e;
      for (int i = 0; i < 6; i++) begin
         drive(t[i]);
         e = expq.pop_front();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL reset_mid_run step %0d: got %h want %h", i, obs, e); end
      end
   endtask

   // Zero linger window: dropping the last request goes straight to STOPPING.
   task automatic test_hold_zero();
      stim_t t[5] = '{'{1'b1, 4'h0, 1'b0, 1'b1, 8'h04, 1'b0},
                      '{1'b0, 4'h1, 1'b0, 1'b1, 8'h82, 1'b0},
                      '{1'b0, 4'h1, 1'b1, 1'b0, 8'h88, 1'b0},
                      '{1'b0, 4'h0, 1'b1, 1'b0, 8'h01, 1'b0},
                      '{1'b0, 4'h0, 1'b0, 1'b1, 8'h04, 1'b0}};
      logic [7:0] e;
      for (int i = 0; i < 5; i++) begin
         drive(t[i]);
         e = expq.pop_front();
         checks++;
         if (obs0 !== e) begin errors++; $display("FAIL hold_zero step %0d: got %h want %h", i, obs0, e); end
      end
   endtask

   task automatic test_checker();
      stim_t t[6] = '{'{1'b1, 4'h0, 1'b0, 1'b1, 8'h04, 1'b0},
                      '{1'b0, 4'h1, 1'b0, 1'b1, 8'h82, 1'b0},
                      '{1'b0, 4'h1, 1'b1, 1'b0, 8'h88, 1'b0},
                      '{1'b0, 4'h1, 1'b0, 1'b0, 8'h82, 1'b1},
                      '{1'b0, 4'h1, 1'b1, 1'b0, 8'h88, 1'b1},
                      '{1'b1, 4'h0, 1'b0, 1'b1, 8'h04, 1'b0}};
      logic [7:0] e;
      for (int i = 0; i < 6; i++) begin
         drive(t[i]);
         e = expq.pop_front();
         checks++;
         if ({obs, perr} !== {e, t[i].err}) begin
            errors++;
            $display("FAIL checker step %0d: got %h/%b want %h/%b", i, obs, perr, e, t[i].err);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single_start();
      test_linger_hold();
      test_back_to_back();
      test_linger_expiry();
      test_request_in_stopping();
      test_reset_mid_run();
      test_hold_zero();
`ifdef CLOCK_JOIN_PROTOCOL_CHECK_EN
      test_checker();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
